md_sched: RTL and testbench



---
 rtl/md_pkg.sv | 31 +++
 rtl/md_arith.sv | 64 ++++++
 rtl/md_sched.sv | 113 +++++++++++
 tb/tb_md_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// the md_op encoding, default busy-window lengths and the FSM state type.
package md_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } md_op_e;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic logic md_is_muldiv(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing {hi, lo}.
// Optional build macro MD_DIVZERO_KEEP_EN: a divide by zero returns the
// prior HI/LO (supplied on hi_in/lo_in) instead of {A, 32'hFFFF_FFFF}.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MD_DIVZERO_KEEP_EN
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
`endif
    output logic [63:0] res
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        ovf;
    logic [31:0] b_div_s;
    logic [31:0] b_div_u;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic [63:0] divzero_res;

    // Products, quotients and result select for the requested operation
    always_comb begin
        a_sx   = {{32{a[31]}}, a};
        b_sx   = {{32{b[31]}}, b};
        prod_s = a_sx * b_sx;
        prod_u = {32'h0, a} * {32'h0, b};

        // Divisor is forced to 1 for zero and for INT_MIN / -1: the zero case
        // is overridden below, and INT_MIN / 1 already yields the wrapped
        // quotient 0x8000_0000 with remainder 0 that INT_MIN / -1 requires.
        ovf     = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        b_div_s = ((b == '0) || ovf) ? 32'd1 : b;
        b_div_u = (b == '0) ? 32'd1 : b;
        quo_s   = $signed(a) / $signed(b_div_s);
        rem_s   = $signed(a) % $signed(b_div_s);
        quo_u   = a / b_div_u;
        rem_u   = a % b_div_u;

`ifdef MD_DIVZERO_KEEP_EN
        divzero_res = {hi_in, lo_in};
`else
        divzero_res = {a, 32'hFFFF_FFFF};
`endif

        res = '0;
        case (op)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV:   res = (b == '0) ? divzero_res : {rem_s, quo_s};
            OP_DIVU:  res = (b == '0) ? divzero_res : {rem_u, quo_u};
            default:  res = '0;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// HI/LO multiply/divide sequencer for the E stage: computes the result at
// issue, hides it behind a fixed busy window, then commits it to HI/LO.
// Optional build macro MD_DIVZERO_KEEP_EN (see md_arith).
module md_sched
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_hi,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      p_hi_q, p_hi_d;
    logic [31:0]      p_lo_q, p_lo_d;
    logic [63:0]      arith_res;

    md_arith u_arith (
        .op    (md_op),
        .a     (A),
        .b     (B),
`ifdef MD_DIVZERO_KEEP_EN
        .hi_in (hi_q),
        .lo_in (lo_q),
`endif
        .res   (arith_res)
    );

    // Next-state, counter, pending-result and HI/LO update logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (md_is_muldiv(md_op)) begin
                        {p_hi_d, p_lo_d} = arith_res;
                        cnt_d   = md_is_div(md_op) ? DIV_LOAD : MULT_LOAD;
                        state_d = ST_RUN;
                    end
                end else if (md_op == OP_MTHI) begin
                    hi_d = A;
                end else if (md_op == OP_MTLO) begin
                    lo_d = A;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    hi_d    = p_hi_q;
                    lo_d    = p_lo_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
    end

    // State and datapath registers; reset discards any in-flight result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
        end
    end

    assign busy    = busy_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign rd_data = rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: stimulus pushes timed expectations derived
// from an arithmetic reference model; a negedge monitor pops and compares.
module tb_md_sched;
    import md_pkg::*;

    localparam int unsigned NM = 5;
    localparam int unsigned ND = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        rd_hi;
    logic [31:0] rd_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    md_sched #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_op   (md_op),
        .A       (A),
        .B       (B),
        .rd_hi   (rd_hi),
        .rd_data (rd_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    typedef struct {
        int unsigned due;
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int unsigned m_busy_until;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int unsigned due, input logic b, input logic [31:0] h,
                        input logic [31:0] l, input string tag);
        exp_t e;
        e.due = due; e.busy = b; e.hi = h; e.lo = l; e.tag = tag;
        sb.push_back(e);
    endtask

    // Reference: results from the arithmetic rules, not from any pipeline view
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi0,
                                           input logic [31:0] lo0);
        longint          sp;
        longint unsigned up;
        logic [31:0]     ma, mb, q, r;
        if ((op == OP_DIV || op == OP_DIVU) && b == 32'h0) begin
`ifdef MD_DIVZERO_KEEP_EN
            return {hi0, lo0};
`else
            return {a, 32'hFFFF_FFFF};
`endif
        end
        case (op)
            OP_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            OP_MULTU: begin
                up = 64'(a) * 64'(b);
                return up;
            end
            OP_DIVU: return {a % b, a / b};
            default: begin
                ma = a[31] ? -a : a;
                mb = b[31] ? -b : b;
                q  = ma / mb;
                r  = ma % mb;
                if (a[31] ^ b[31]) q = -q;
                if (a[31]) r = -r;
                return {r, q};
            end
        endcase
    endfunction

    // Monitor: compare every expectation whose due cycle has arrived
    initial forever begin
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due != cyc) begin
                check32({e.tag, "_due"}, cyc, e.due);
            end else begin
                check32({e.tag, "_busy"}, {31'h0, busy}, {31'h0, e.busy});
                check32({e.tag, "_hi"}, hi, e.hi);
                check32({e.tag, "_lo"}, lo, e.lo);
                check32({e.tag, "_rd"}, rd_data, rd_hi ? e.hi : e.lo);
            end
        end
    end

    task automatic issue(input logic s, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        int unsigned t, n;
        logic [63:0] r;
        start = s; md_op = op; A = a; B = b; rd_hi = 1'($urandom);
        t = cyc + 1;
        if (s && (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU)) begin
            n = (op == OP_DIV || op == OP_DIVU) ? ND : NM;
            r = ref_md(op, a, b, m_hi, m_lo);
            push(t, 1'b1, m_hi, m_lo, "issue");
            if (n > 1) push(t + n - 1, 1'b1, m_hi, m_lo, "window_end");
            m_hi = r[63:32];
            m_lo = r[31:0];
            push(t + n, 1'b0, m_hi, m_lo, "commit");
            m_busy_until = t + n;
        end else begin
            if (!s && op == OP_MTHI) m_hi = a;
            if (!s && op == OP_MTLO) m_lo = a;
            push(t, 1'b0, m_hi, m_lo, "move");
        end
        @(posedge clk); #1;
        start = 1'b0; md_op = OP_NONE; A = $urandom; B = $urandom;
    endtask

    // Wait out the busy window while throwing ignored moves at the DUT
    task automatic wait_idle();
        while (cyc < m_busy_until) begin
            case ($urandom_range(0, 2))
                0:       md_op = OP_MTHI;
                1:       md_op = OP_MTLO;
                default: md_op = OP_NONE;
            endcase
            A = $urandom; rd_hi = 1'($urandom);
            @(posedge clk); #1;
        end
        md_op = OP_NONE;
    endtask

    task automatic idle_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            rd_hi = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0;
        logic [2:0]  op;
        logic        s;
        logic [31:0] a, b;

        reset = 1'b1; start = 1'b0; md_op = OP_NONE; A = '0; B = '0; rd_hi = 1'b0;
        m_hi = '0; m_lo = '0; m_busy_until = 0;
        @(posedge clk); @(posedge clk); #1;
        check32("reset_busy", {31'h0, busy}, 32'h0);
        check32("reset_hi", hi, 32'h0);
        check32("reset_lo", lo, 32'h0);
        reset = 1'b0;
        idle_cycles(2);

        issue(1'b1, OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_idle();
        check32("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check32("mult_neg_lo", lo, 32'hFFFF_FFEB);

        issue(1'b1, OP_DIVU, 32'd100, 32'd7);
        wait_idle();
        check32("divu_lo", lo, 32'd14);
        check32("divu_hi", hi, 32'd2);

        issue(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        check32("div_neg_lo", lo, 32'hFFFF_FFFD);
        check32("div_neg_hi", hi, 32'hFFFF_FFFF);

        issue(1'b0, OP_MTLO, 32'h1234_5678, 32'h0);
        check32("mtlo_lo", lo, 32'h1234_5678);
        check32("mtlo_busy", {31'h0, busy}, 32'h0);

        issue(1'b1, OP_MULT, 32'h10, 32'h20);
        md_op = OP_MTHI; A = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        md_op = OP_NONE;
        wait_idle();
        check32("mthi_ignored_hi", hi, 32'h0);
        check32("mthi_ignored_lo", lo, 32'h200);

        issue(1'b1, OP_DIV, 32'd5, 32'd0);
        wait_idle();
`ifdef MD_DIVZERO_KEEP_EN
        check32("divzero_hi", hi, 32'h0);
        check32("divzero_lo", lo, 32'h200);
`else
        check32("divzero_hi", hi, 32'd5);
        check32("divzero_lo", lo, 32'hFFFF_FFFF);
`endif

        issue(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_idle();
        check32("b2b_multu_hi", hi, 32'd1);
        check32("b2b_multu_lo", lo, 32'hFFFF_FFFE);
        issue(1'b1, OP_DIVU, 32'd9, 32'd3);
        wait_idle();
        check32("b2b_divu_lo", lo, 32'd3);
        check32("b2b_divu_hi", hi, 32'd0);

        issue(1'b1, OP_DIV, 32'd1000, 32'd3);
        idle_cycles(2);
        reset = 1'b1;
        #1;
        check32("async_rst_busy", {31'h0, busy}, 32'h0);
        check32("async_rst_hi", hi, 32'h0);
        check32("async_rst_lo", lo, 32'h0);
        sb.delete();
        m_hi = '0; m_lo = '0; m_busy_until = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        t0 = cyc;
        push(t0 + 12, 1'b0, 32'h0, 32'h0, "no_commit_after_reset");
        idle_cycles(14);

        issue(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();

        for (int i = 0; i < 150; i++) begin
            wait_idle();
            idle_cycles($urandom_range(0, 2));
            op = 3'($urandom_range(0, 6));
            if (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU)
                s = ($urandom_range(0, 7) != 0);
            else
                s = ($urandom_range(0, 3) == 0);
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = -32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            issue(s, op, a, b);
        end
        wait_idle();
        idle_cycles(3);
        check32("scoreboard_drained", sb.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
